mem_port_arbiter: RTL

Round-robin arbiter that shares the single main-memory load/write port among NUM_REQ processing blocks. Each processing block presents one load or write request with a valid/ready handshake. The arbiter issues one transaction at a time to memory, waits the fixed read latency, and returns a one-hot response strobe to the owning requester. It sits between the processing-block array and main memory.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single main-memory load/write port among NUM_REQ processing
// blocks. A round-robin arbiter accepts one request at a time, issues it to
// memory for one cycle, waits out the read latency for loads, and returns a
// one-hot completion strobe to the owning requester.
//
// Optional feature macro: MEM_ARB_WRITE_FIRST_EN
//   defined   -> pending writes win arbitration over pending loads
//                (round-robin among the writers only)
//   undefined -> pure round-robin over req_valid, req_write ignored for
//                selection
module mem_port_arbiter #(
    parameter int  CORES       = 32,
    parameter int  BITS        = 16,
    parameter int  NUM_REQ     = 4,
    parameter int  MEM_LATENCY = 2,
    localparam int DW          = CORES * BITS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*16-1:0]   req_addr,
    input  logic [NUM_REQ*DW-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [DW-1:0]           rsp_data,
    output logic [15:0]             mem_addr,
    output logic [DW-1:0]           mem_wdata,
    output logic                    mem_we,
    output logic                    mem_re,
    input  logic [DW-1:0]           mem_rdata,
    output logic                    busy
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    // Owner of the current transaction; also the round-robin pointer.
    logic [GW-1:0]      last_grant_reg;
    logic               write_reg;
    logic [CW-1:0]      cnt_reg;
    logic [15:0]        mem_addr_reg;
    logic [DW-1:0]      mem_wdata_reg;
    logic [DW-1:0]      rsp_data_reg;

    // Arbitration results
    logic [NUM_REQ-1:0] cand;
    logic               win_found;
    logic [GW-1:0]      win_idx;
    logic [GW-1:0]      scan_idx;

    // Pick the first candidate after the last grant, wrapping around.
    always_comb begin
        cand = req_valid;
`ifdef MEM_ARB_WRITE_FIRST_EN
        // Writers pre-empt loaders whenever at least one write is pending.
        if ((req_valid & req_write) != '0) begin
            cand = req_valid & req_write;
        end
`endif
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = GW'((int'(last_grant_reg) + k) % NUM_REQ);
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // State register; reset aborts any in-flight transaction immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: one transaction outstanding at most.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_found) state_next = ISSUE;
            ISSUE:   state_next = write_reg ? RESP : WAIT;
            WAIT:    if (cnt_reg == CW'(1)) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: strobes are pure functions of state and latched owner.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        busy      = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    req_ready = NUM_REQ'(1) << win_idx;
                end
            end
            ISSUE: begin
                mem_we = write_reg;
                mem_re = !write_reg;
            end
            RESP: begin
                rsp_valid = NUM_REQ'(1) << last_grant_reg;
            end
            default: ;
        endcase
    end

    // Transaction datapath: latch on accept, count latency, capture load data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_reg <= GW'(NUM_REQ - 1);
            write_reg      <= 1'b0;
            cnt_reg        <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            rsp_data_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        last_grant_reg <= win_idx;
                        write_reg      <= req_write[win_idx];
                        mem_addr_reg   <= req_addr[win_idx * 16 +: 16];
                        mem_wdata_reg  <= req_wdata[win_idx * DW +: DW];
                    end
                end
                ISSUE: begin
                    cnt_reg <= CW'(MEM_LATENCY);
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    // Last wait cycle is the one where memory data is valid.
                    if (cnt_reg == CW'(1)) begin
                        rsp_data_reg <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign rsp_data  = rsp_data_reg;

endmodule
